// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: funct3 encodings and arbiter state type shared by the data-memory port logic
package dmem_port_arbiter_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {IDLE, LD_WAIT, RESP, RMW_RD, RMW_WAIT, RMW_WR} arb_state_t;

    function automatic logic st_funct3_ok(input logic [2:0] f);
        return f == F3_SB || f == F3_SH || f == F3_SW;
    endfunction
endpackage

// File: rtl/dmem_store_merge.sv
// dmem_store_merge: splices SB/SH store data into the old memory word; SW replaces the whole word
module dmem_store_merge
    import dmem_port_arbiter_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] merged
);
    always_comb begin
        merged = old_word;
        if (funct3 == F3_SB)
            merged[{addr, 3'b000} +: 8] = st_data[7:0];
        else if (funct3 == F3_SH)
            merged[{addr[1], 4'b0000} +: 16] = st_data[15:0];
        else
            merged = st_data;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between loads and committed stores, with RMW for SB/SH
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int TAG_WIDTH    = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    input  logic [TAG_WIDTH-1:0]  ld_tag,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [2:0]            st_funct3,
    output logic                  st_err,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [2:0]            mem_funct3,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t            state;
    logic [CW-1:0]         starve_cnt;
    logic                  kill;
    logic [ADDR_WIDTH-1:0] sa;
    logic [DATA_WIDTH-1:0] sd;
    logic [2:0]            sf;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [31:0]           merged;
    logic idle, st_grant, ld_grant, st_bad, st_word, st_rmw;

    dmem_store_merge u_merge (
        .old_word(mem_rdata),
        .st_data (sd),
        .addr    (sa[1:0]),
        .funct3  (sf),
        .merged  (merged)
    );

    // Stores win unless a waiting load has already been passed over STARVE_LIMIT times
    assign idle     = state == IDLE && !rst;
    assign st_grant = idle && st_valid && !(ld_valid && starve_cnt == LIMIT);
    assign ld_grant = idle && ld_valid && !st_grant;
    assign st_bad   = !st_funct3_ok(st_funct3) || (st_addr >> 2) >= ADDR_WIDTH'(DEPTH);
    assign st_word  = st_grant && !st_bad && st_funct3 == F3_SW;
    assign st_rmw   = st_grant && !st_bad && st_funct3 != F3_SW;

    assign ld_ready     = ld_grant;
    assign st_ready     = (st_grant && !st_rmw) || state == RMW_WR;
    assign st_err       = st_grant && st_bad;
    assign resp_valid   = state == RESP;
    assign mem_read_en  = ld_grant || state == RMW_RD;
    assign mem_raddr    = ld_grant ? ld_addr : state == RMW_RD ? {sa[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_funct3   = ld_grant ? ld_funct3 : state == RMW_RD ? F3_LW : '0;
    assign mem_write_en = st_word || state == RMW_WR;
    assign mem_waddr    = st_word ? st_addr >> 2 : state == RMW_WR ? sa >> 2 : '0;
    assign mem_wdata    = st_word ? st_data : state == RMW_WR ? merged_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            kill       <= 1'b0;
            sa         <= '0;
            sd         <= '0;
            sf         <= '0;
            tag_q      <= '0;
            merged_q   <= '0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else begin
            starve_cnt <= (!ld_valid || ld_grant) ? '0 : st_grant ? starve_cnt + 1'b1 : starve_cnt;
            case (state)
                IDLE: begin
                    if (ld_grant) begin
                        state <= LD_WAIT;
                        tag_q <= ld_tag;
                        kill  <= flush;
                    end else if (st_rmw) begin
                        state <= RMW_RD;
                        sa    <= st_addr;
                        sd    <= st_data;
                        sf    <= st_funct3;
                    end
                end
                LD_WAIT: begin
                    if (mem_rdata_valid) begin
                        state <= (kill || flush) ? IDLE : RESP;
                        kill  <= 1'b0;
                        if (!(kill || flush)) begin
                            resp_data <= mem_rdata;
                            resp_tag  <= tag_q;
                        end
                    end else begin
                        kill <= kill || flush;
                    end
                end
                RESP:     state <= (flush || resp_ready) ? IDLE : RESP;
                RMW_RD:   state <= RMW_WAIT;
                RMW_WAIT: begin
                    if (mem_rdata_valid) begin
                        merged_q <= merged;
                        state    <= RMW_WR;
                    end
                end
                RMW_WR:   state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule
